// File: rtl/add_serial_seq.sv
// Sequencer feeding the 8-bit bit-serial adder: 2-entry operand FIFO, issue/wait/capture/release FSM, result register.
// Optional sum checker enabled by defining ADD_SERIAL_SEQ_CHECK_EN (err tied low otherwise).
module add_serial_seq #(
    parameter int WAIT_CYC      = 10,
    parameter bit EN_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_en,
    input  logic [7:0] add_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       err
);
    localparam int            CW        = $clog2(WAIT_CYC);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fifo_mem_q [2];
    logic [15:0]   fifo_mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [7:0]    add_a_q, add_a_d;
    logic [7:0]    add_b_q, add_b_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;
    logic          push, pop, capture, en_raw;

    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid && in_ready;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_en    = en_raw ^ EN_ACTIVE_LOW;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    always_comb begin
        state_d     = state_q;
        fifo_mem_d  = fifo_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        wait_cnt_d  = wait_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        pop         = 1'b0;
        capture     = 1'b0;
        en_raw      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != 2'd0) begin
                    add_a_d = fifo_mem_q[rd_ptr_q][15:8];
                    add_b_d = fifo_mem_q[rd_ptr_q][7:0];
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                en_raw     = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Adder holds its result in DONE, so stalling here is safe.
                if (!res_valid_q || res_ready) begin
                    capture = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                en_raw  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A consumed result clears, but a reload in the same cycle wins.
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = add_out;
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {in_a, in_b};
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            add_a_q     <= 8'h00;
            add_b_q     <= 8'h00;
            wait_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            wait_cnt_q  <= wait_cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (rst) begin
                    fifo_mem_q[gi] <= 16'h0000;
                end else begin
                    fifo_mem_q[gi] <= fifo_mem_d[gi];
                end
            end
        end
    endgenerate

`ifdef ADD_SERIAL_SEQ_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] local_sum;

    always_comb begin
        local_sum = add_a_q + add_b_q;
        err_d     = err_q;
        if (capture && (local_sum != add_out)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
